arm_run_harness: RTL and testbench
==================================

# arm_run_harness

Synthesizable run controller and result checker for the ARM single-cycle core. It sequences the core's reset and mode, counts execution cycles, and compares a parametrised number of exposed memory words against expected values. It reports pass, fail or timeout with cycle count and first mismatch index. It sits between the board/test environment and `ARM_cpu`, generalising fixed-length, seven-word manual inspection into a parametrised, self-checking, restartable run.

## Interface
Parameters:
- `DATA_W`, 32, width of each observed memory word.
- `NUM_WORDS`, 7, number of observed words (≥1).
- `RESET_CYCLES`, 1, cycles the core is held in reset per run (≥1).
- `TIMEOUT`, 750, maximum RUN cycles before FAIL (≥2).
- `STABLE_CYCLES`, 4, consecutive all-match cycles required for PASS (≥1).
- Derived: `CNT_W = $clog2(TIMEOUT+1)`; `IDX_W = max(1, $clog2(NUM_WORDS))`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset (rst=0 resets on rising `clk`).
- `start` in 1: run request, sampled each cycle.
- `mode_in` in 1: core mode, latched on an accepted start.
- `mem_flat` in NUM_WORDS*DATA_W: observed words; word i at [i*DATA_W +: DATA_W].
- `exp_flat` in NUM_WORDS*DATA_W: expected words, same packing, must be held stable during a run.
- `cpu_rst` out 1: active-high reset to core.
- `cpu_mode` out 1: mode to core.
- `busy` out 1: run in progress.
- `done` out 1: run finished.
- `pass` out 1: valid when `done`.
- `cycle_count` out CNT_W: RUN cycles elapsed.
- `match_vec` out NUM_WORDS: registered per-word equality.
- `mismatch_idx` out IDX_W: lowest non-matching index at FAIL.

## Operation
- States: IDLE, RESET, RUN, PASS, FAIL.
- Reset (rst=0): state IDLE, `cpu_rst`=1, `cpu_mode`=0, `busy`=0, `done`=0, `pass`=0, `cycle_count`=0, `match_vec`=0, `mismatch_idx`=0, internal counters 0.
- IDLE: `cpu_rst`=1. On start=1: latch `mode_in` into `cpu_mode`, go to RESET.
- RESET: `cpu_rst`=1, `busy`=1. After RESET_CYCLES cycles, go to RUN. `cpu_rst`=0 from the first RUN cycle.
- RUN:
  - `cycle_count` increments every cycle.
  - `match_vec[i]` <= (word i of mem_flat == word i of exp_flat) every cycle.
  - The stable counter increments when `match_vec` is all ones and clears otherwise.
- RUN → PASS when the stable counter reaches STABLE_CYCLES.
- RUN → FAIL when `cycle_count` reaches TIMEOUT-1 without a PASS. Capture `mismatch_idx` = lowest i with `match_vec[i]`=0. If all words match but are not yet stable, `mismatch_idx`=0.
- If the PASS and FAIL conditions occur in the same cycle, PASS wins.
- PASS/FAIL: `done`=1, `busy`=0, `pass`=1 (PASS) or 0 (FAIL).
  - `cpu_rst` stays 0, so the core keeps running and memory stays observable.
  - `cycle_count`, `match_vec` and `mismatch_idx` are frozen.
- start=1 in PASS/FAIL: clear `done`, `pass`, counters and `match_vec`; latch the new mode; go to RESET.
- start is ignored in RESET and RUN. `mode_in` is ignored except on an accepted start.
- rst=0 in any state, including mid-RUN, returns to the reset values on the next edge.

## Timing
- All outputs are registered.
- start accepted at edge N: RESET is entered and `busy`=1 after edge N. `cpu_rst` stays 1 through edge N+RESET_CYCLES, then falls.
- `match_vec` lags `mem_flat` by 1 cycle.
- Earliest PASS: `done` rises STABLE_CYCLES+1 edges after the first RUN edge where memory already matches.
- FAIL: `done` rises on the edge where `cycle_count` would become TIMEOUT. At that point `cycle_count` reads TIMEOUT-1.
- `cycle_count` never wraps; it is bounded by TIMEOUT-1.

## Structure
- Shared package `arm_harness_pkg` holds:
  - the state encoding localparams (IDLE=0, RESET=1, RUN=2, PASS=3, FAIL=4, 3-bit);
  - the width helper for CNT_W and IDX_W.
- One sub-module, `first_zero_idx`: parametrised priority encoder (NUM_WORDS in, IDX_W out, lowest index wins).
- The FSM, counters and comparators live in `arm_run_harness`.

## Test plan
- Reset with start held high and rst=0 → `cpu_rst`=1 and `busy`, `done` and `pass` all 0 until rst=1; start then accepted on the next edge.
- Defaults, `exp_flat` equal to a constant `mem_flat` from cycle 0, start pulse with `mode_in`=1 → `cpu_mode`=1, `cpu_rst` low after 1 cycle, `done`=1 and `pass`=1 with `cycle_count`=4.
- Word 3 never matches → FAIL at `cycle_count`=749, `pass`=0, `mismatch_idx`=3, `match_vec`=7'b1110111.
- All words match for 3 cycles, break one, then match permanently from cycle 20 → stable counter restarts; PASS with `cycle_count`=24.
- Start pulses during RUN are ignored. A start in PASS with `mode_in`=0 restarts: `done`=0, `cpu_rst`=1 for 1 cycle, `cpu_mode`=0.
- rst=0 at `cycle_count`=100 mid-RUN → all outputs return to their reset values next edge; `cpu_rst`=1.

Source files
------------

// File: rtl/arm_harness_pkg.sv
// Shared definitions for the ARM run harness: FSM state encoding and width helpers.
package arm_harness_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReset = 3'd1,
    StRun   = 3'd2,
    StPass  = 3'd3,
    StFail  = 3'd4
  } state_e;

  // Bits needed to hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/first_zero_idx.sv
// Priority encoder: index of the lowest clear bit in vec, zero when all bits are set.
module first_zero_idx #(
  parameter int unsigned NUM_WORDS = 7,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [NUM_WORDS-1:0] vec,
  output logic [IDX_W-1:0]     idx
);

  // Scan from the top so the lowest clear bit is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = NUM_WORDS - 1; i >= 0; i--) begin
      if (!vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/arm_run_harness.sv
// Run controller for the ARM core: sequences core reset/mode, counts run cycles and
// checks a set of exposed memory words against expected values until pass or timeout.
module arm_run_harness
  import arm_harness_pkg::*;
#(
  parameter int unsigned  DATA_W        = 32,
  parameter int unsigned  NUM_WORDS     = 7,
  parameter int unsigned  RESET_CYCLES  = 1,
  parameter int unsigned  TIMEOUT       = 750,
  parameter int unsigned  STABLE_CYCLES = 4,
  localparam int unsigned CNT_W         = cnt_width(TIMEOUT),
  localparam int unsigned IDX_W         = idx_width(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mode_in,
  input  logic [NUM_WORDS*DATA_W-1:0] mem_flat,
  input  logic [NUM_WORDS*DATA_W-1:0] exp_flat,
  output logic                        cpu_rst,
  output logic                        cpu_mode,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [NUM_WORDS-1:0]        match_vec,
  output logic [IDX_W-1:0]            mismatch_idx
);

  localparam int unsigned SW = cnt_width(STABLE_CYCLES);
  localparam int unsigned RW = cnt_width(RESET_CYCLES);

  state_e               state_q, state_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 cpu_mode_q, cpu_mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_WORDS-1:0] match_q, match_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SW-1:0]        stable_q, stable_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;

  logic [NUM_WORDS-1:0] word_eq;
  logic [IDX_W-1:0]     first_zero;

  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      word_eq[i] = (mem_flat[i*DATA_W +: DATA_W] == exp_flat[i*DATA_W +: DATA_W]);
    end
  end

  first_zero_idx #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_first_zero (
    .vec (match_q),
    .idx (first_zero)
  );

  always_comb begin
    state_d    = state_q;
    cpu_rst_d  = cpu_rst_q;
    cpu_mode_d = cpu_mode_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    match_d    = match_q;
    idx_d      = idx_q;
    stable_d   = stable_q;
    rcnt_d     = rcnt_q;

    case (state_q)
      StIdle: begin
        cpu_rst_d = 1'b1;
        if (start) begin
          state_d    = StReset;
          cpu_mode_d = mode_in;
          busy_d     = 1'b1;
          rcnt_d     = '0;
        end
      end
      StReset: begin
        if (rcnt_q == RW'(RESET_CYCLES - 1)) begin
          state_d   = StRun;
          cpu_rst_d = 1'b0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      StRun: begin
        match_d  = word_eq;
        stable_d = (&match_q) ? stable_q + SW'(1) : '0;
        // Pass is checked first so it wins over a simultaneous timeout.
        // match_vec and cycle_count hold on the terminating edge so they agree
        // with the captured mismatch index.
        if (stable_d == SW'(STABLE_CYCLES)) begin
          state_d = StPass;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b1;
          match_d = match_q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = StFail;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          idx_d   = first_zero;
          match_d = match_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPass, StFail: begin
        if (start) begin
          state_d    = StReset;
          cpu_rst_d  = 1'b1;
          cpu_mode_d = mode_in;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          cnt_d      = '0;
          match_d    = '0;
          idx_d      = '0;
          stable_d   = '0;
          rcnt_d     = '0;
        end
      end
      default: begin
        state_d   = StIdle;
        cpu_rst_d = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pass_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cpu_rst_q  <= 1'b1;
      cpu_mode_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      cnt_q      <= '0;
      match_q    <= '0;
      idx_q      <= '0;
      stable_q   <= '0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cpu_rst_q  <= cpu_rst_d;
      cpu_mode_q <= cpu_mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      idx_q      <= idx_d;
      stable_q   <= stable_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign cpu_rst      = cpu_rst_q;
  assign cpu_mode     = cpu_mode_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign cycle_count  = cnt_q;
  assign match_vec    = match_q;
  assign mismatch_idx = idx_q;

endmodule

// File: tb/tb_arm_run_harness.sv
// Directed self-checking bench for arm_run_harness with default parameters.
module tb_arm_run_harness;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_WORDS = 7;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned IDX_W     = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic                        mode_in;
  logic [NUM_WORDS*DATA_W-1:0] mem_flat;
  logic [NUM_WORDS*DATA_W-1:0] exp_flat;
  logic                        cpu_rst;
  logic                        cpu_mode;
  logic                        busy;
  logic                        done;
  logic                        pass;
  logic [CNT_W-1:0]            cycle_count;
  logic [NUM_WORDS-1:0]        match_vec;
  logic [IDX_W-1:0]            mismatch_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int k;

  always #5 clk = ~clk;

  arm_run_harness dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode_in      (mode_in),
    .mem_flat     (mem_flat),
    .exp_flat     (exp_flat),
    .cpu_rst      (cpu_rst),
    .cpu_mode     (cpu_mode),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .cycle_count  (cycle_count),
    .match_vec    (match_vec),
    .mismatch_idx (mismatch_idx)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference word i is a fixed pattern; a set bit in flip corrupts that word.
  function automatic logic [NUM_WORDS*DATA_W-1:0] make_words(input logic [NUM_WORDS-1:0] flip);
    logic [NUM_WORDS*DATA_W-1:0] v;
    for (int i = 0; i < NUM_WORDS; i++) begin
      v[i*DATA_W +: DATA_W] = (32'hA5A5_0000 + 32'(i) * 32'h1111) ^
                              (flip[i] ? 32'h8000_0001 : 32'h0);
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; afterwards the harness is at run cycle 0.
  task automatic start_run(input logic mode);
    start   = 1'b1;
    mode_in = mode;
    step();
    start   = 1'b0;
    mode_in = ~mode;
    check_eq("acc_busy", busy, 1);
    check_eq("acc_cpu_rst", cpu_rst, 1);
    check_eq("acc_cpu_mode", cpu_mode, mode);
    check_eq("acc_done", done, 0);
    check_eq("acc_pass", pass, 0);
    check_eq("acc_cnt", cycle_count, 0);
    check_eq("acc_match", match_vec, 0);
    check_eq("acc_idx", mismatch_idx, 0);
    step();
    check_eq("run_cpu_rst", cpu_rst, 0);
    check_eq("run_busy", busy, 1);
    check_eq("run_cnt", cycle_count, 0);
  endtask

  // During run cycle c the words in mask mismatch when lo <= c < hi; start pulses at
  // cycle pulse_at. Returns number of edges stepped (stops at done or stop_at).
  task automatic run_pattern(input logic [NUM_WORDS-1:0] mask, input int lo, input int hi,
                             input int stop_at, input int pulse_at, output int edges);
    int c;
    c = 0;
    mem_flat = make_words((c >= lo && c < hi) ? mask : '0);
    forever begin
      step();
      c++;
      if (done || c >= stop_at) break;
      mem_flat = make_words((c >= lo && c < hi) ? mask : '0);
      start    = (c == pulse_at);
      mode_in  = 1'b1;
    end
    start = 1'b0;
    edges = c;
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b1;
    mode_in  = 1'b1;
    exp_flat = make_words('0);
    mem_flat = make_words('0);

    // Reset dominates a held start.
    repeat (3) step();
    check_eq("rst_cpu_rst", cpu_rst, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_cpu_mode", cpu_mode, 0);
    check_eq("rst_cnt", cycle_count, 0);
    check_eq("rst_match", match_vec, 0);
    rst = 1'b1;

    // Constant match from cycle 0: earliest pass.
    start_run(1'b1);
    run_pattern('0, 0, 0, 50, -1, k);
    check_eq("p1_edges", k, 5);
    check_eq("p1_done", done, 1);
    check_eq("p1_pass", pass, 1);
    check_eq("p1_cnt", cycle_count, 4);
    check_eq("p1_match", match_vec, 7'h7F);
    check_eq("p1_busy", busy, 0);
    check_eq("p1_cpu_rst", cpu_rst, 0);
    check_eq("p1_cpu_mode", cpu_mode, 1);

    // Restart from PASS with mode 0; word 1 breaks for cycles 3..19; start in RUN ignored.
    start_run(1'b0);
    run_pattern(7'b0000010, 3, 20, 100, 10, k);
    check_eq("p2_edges", k, 25);
    check_eq("p2_done", done, 1);
    check_eq("p2_pass", pass, 1);
    check_eq("p2_cnt", cycle_count, 24);
    check_eq("p2_cpu_mode", cpu_mode, 0);
    mem_flat = make_words(7'b0000100);
    repeat (3) step();
    check_eq("p2_hold_cnt", cycle_count, 24);
    check_eq("p2_hold_match", match_vec, 7'h7F);
    check_eq("p2_hold_done", done, 1);

    // Word 3 never matches: timeout.
    start_run(1'b1);
    run_pattern(7'b0001000, 0, 100000, 800, -1, k);
    check_eq("f1_edges", k, 750);
    check_eq("f1_done", done, 1);
    check_eq("f1_pass", pass, 0);
    check_eq("f1_cnt", cycle_count, 749);
    check_eq("f1_idx", mismatch_idx, 3);
    check_eq("f1_match", match_vec, 7'b1110111);
    check_eq("f1_cpu_rst", cpu_rst, 0);
    mem_flat = make_words('0);
    repeat (3) step();
    check_eq("f1_hold_cnt", cycle_count, 749);
    check_eq("f1_hold_match", match_vec, 7'b1110111);
    check_eq("f1_hold_done", done, 1);

    // Reset in the middle of a run.
    start_run(1'b1);
    run_pattern(7'b0001000, 0, 100000, 100, -1, k);
    check_eq("mr_edges", k, 100);
    check_eq("mr_cnt", cycle_count, 100);
    check_eq("mr_busy", busy, 1);
    rst = 1'b0;
    step();
    check_eq("mr_cpu_rst", cpu_rst, 1);
    check_eq("mr_cpu_mode", cpu_mode, 0);
    check_eq("mr_busy0", busy, 0);
    check_eq("mr_done", done, 0);
    check_eq("mr_pass", pass, 0);
    check_eq("mr_cnt0", cycle_count, 0);
    check_eq("mr_match", match_vec, 0);
    check_eq("mr_idx", mismatch_idx, 0);
    rst = 1'b1;
    step();
    check_eq("mr_idle_busy", busy, 0);
    check_eq("mr_idle_cpu_rst", cpu_rst, 1);

    // Two broken words: the lower index is reported.
    start_run(1'b0);
    run_pattern(7'b1100000, 0, 100000, 800, -1, k);
    check_eq("f2_edges", k, 750);
    check_eq("f2_pass", pass, 0);
    check_eq("f2_idx", mismatch_idx, 5);
    check_eq("f2_match", match_vec, 7'b0011111);
    check_eq("f2_cpu_mode", cpu_mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
